// File: rtl/hps_tx_fifo.sv
// Show-ahead single-clock TX FIFO between the HPS lightweight bridge and fabric stream logic.
// Optional almost-full output and status bit enabled by defining HPS_TX_FIFO_AFULL_EN.
module hps_tx_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_LVL  = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            avs_address,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  input  logic                  avs_read,
  output logic [31:0]           avs_readdata,
  output logic [DATA_W-1:0]     st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  wrfull,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  overflow
`ifdef HPS_TX_FIFO_AFULL_EN
  , output logic                almost_full
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   usedw_q, usedw_d;
  logic                  wrfull_q, wrfull_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [31:0]           status;
  logic                  push_req, push, pop, flush, ovf_clr;
`ifdef HPS_TX_FIFO_AFULL_EN
  logic                  afull_q, afull_d;
`endif

  assign st_valid     = (usedw_q != '0);
  assign st_data      = mem_q[rd_ptr_q];
  assign wrfull       = wrfull_q;
  assign usedw        = usedw_q;
  assign overflow     = overflow_q;
  assign avs_readdata = readdata_q;
`ifdef HPS_TX_FIFO_AFULL_EN
  assign almost_full  = afull_q;
`endif

  always_comb begin
    push_req = avs_write && (avs_address == 2'd0);
    push     = push_req && !wrfull_q;
    pop      = st_ready && st_valid;
    flush    = avs_write && (avs_address == 2'd2) && avs_writedata[0];
    ovf_clr  = avs_write && (avs_address == 2'd2) && avs_writedata[1];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    // Flush wins over any push/pop in the same cycle.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      usedw_d = usedw_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end
    wrfull_d = (usedw_d == FULL_CNT);
`ifdef HPS_TX_FIFO_AFULL_EN
    afull_d  = (32'(usedw_d) >= 32'(AFULL_LVL));
`endif

    // A dropped push sets the flag even if a clear arrives the same cycle.
    overflow_d = overflow_q;
    if (push_req && wrfull_q) overflow_d = 1'b1;
    else if (ovf_clr)         overflow_d = 1'b0;

    status = '0;
    status[31] = overflow_q;
    status[30] = wrfull_q;
    status[29] = st_valid;
`ifdef HPS_TX_FIFO_AFULL_EN
    status[28] = afull_q;
`endif
    status[DEPTH_LOG2:0] = usedw_q;

    readdata_d = readdata_q;
    if (avs_read) readdata_d = (avs_address == 2'd1) ? status : 32'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usedw_q    <= '0;
      wrfull_q   <= 1'b0;
      overflow_q <= 1'b0;
      readdata_q <= '0;
`ifdef HPS_TX_FIFO_AFULL_EN
      afull_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      usedw_q    <= usedw_d;
      wrfull_q   <= wrfull_d;
      overflow_q <= overflow_d;
      readdata_q <= readdata_d;
`ifdef HPS_TX_FIFO_AFULL_EN
      afull_q    <= afull_d;
`endif
    end
  end

  // Storage needs no reset; contents are only visible while st_valid is high.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= avs_writedata[DATA_W-1:0];
  end

endmodule
